// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift_arbiter block: default widths, shift
// direction encodings and the result-buffer FSM state type.
package shift_arbiter_pkg;

  localparam int WIDTH_DEF  = 5;
  localparam int DIST_W_DEF = 3;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } dir_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational logical shifter: zero-filled left/right shift, truncated to
// WIDTH; any distance of WIDTH or more yields all zeros.
module shift_arbiter_shifter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic [WIDTH-1:0]  in,
  input  logic [DIST_W-1:0] distance,
  input  logic              direction,
  output logic [WIDTH-1:0]  out
);

  // NOTE: every output of an always_comb block is assigned a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    out = '0;
    if (int'(distance) < WIDTH) begin
      if (direction == SHIFT_LEFT) out = in << distance;
      else                         out = in >> distance;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared shifter with a one-entry result
// buffer. Define SHIFT_ARBITER_RR_EN for round-robin; otherwise requester 0 wins.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [WIDTH-1:0]  req0_in,
  input  logic [DIST_W-1:0] req0_distance,
  input  logic              req0_direction,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WIDTH-1:0]  req1_in,
  input  logic [DIST_W-1:0] req1_distance,
  input  logic              req1_direction,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_out,
  output logic              rsp_id,
  input  logic              rsp_ready
);

  state_e            state;
  logic              grant0;
  logic              grant1;
  logic              buf_free;
  logic              accept;
  logic [WIDTH-1:0]  sel_in;
  logic [DIST_W-1:0] sel_distance;
  logic              sel_direction;
  logic [WIDTH-1:0]  shifted;

`ifdef SHIFT_ARBITER_RR_EN
  // ptr==0 favours requester 0 on contention, ptr==1 favours requester 1.
  logic ptr;

  assign grant0 = req0_valid && (!req1_valid || !ptr);
  assign grant1 = req1_valid && (!req0_valid ||  ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= ~grant1;
  end
`else
  assign grant0 = req0_valid;
  assign grant1 = req1_valid && !req0_valid;
`endif

  assign rsp_valid  = (state == FULL);
  assign buf_free   = !rsp_valid || rsp_ready;
  // Gated by rst_n so nothing is offered while the block is held in reset.
  assign req0_ready = rst_n && grant0 && buf_free;
  assign req1_ready = rst_n && grant1 && buf_free;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    sel_in        = req0_in;
    sel_distance  = req0_distance;
    sel_direction = req0_direction;
    if (grant1) begin
      sel_in        = req1_in;
      sel_distance  = req1_distance;
      sel_direction = req1_direction;
    end
  end

  shift_arbiter_shifter #(
    .WIDTH  (WIDTH),
    .DIST_W (DIST_W)
  ) u_shifter (
    .in        (sel_in),
    .distance  (sel_distance),
    .direction (sel_direction),
    .out       (shifted)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rsp_out <= '0;
      rsp_id  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state   <= FULL;
            rsp_out <= shifted;
            rsp_id  <= grant1;
          end
        end
        FULL: begin
          if (accept) begin
            rsp_out <= shifted;
            rsp_id  <= grant1;
          end else if (rsp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
